// File: rtl/md_pkg.sv
// md_pkg: shared constants and state encoding for the RV32M multiply/divide sequencer
package md_pkg;
  localparam int MD_XLEN = 32;
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state_e;
endpackage

// File: rtl/md_div_step.sv
// md_div_step: one combinational restoring-division step producing one quotient bit
module md_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] dvs,
  input  logic            din,
  output logic [XLEN-1:0] rem_nxt,
  output logic            q
);
  logic [XLEN:0] sh, diff;
  assign sh      = {rem, din};
  assign diff    = sh - {1'b0, dvs};
  assign q       = ~diff[XLEN];
  assign rem_nxt = q ? diff[XLEN-1:0] : sh[XLEN-1:0];
endmodule

// File: rtl/md_seq.sv
// md_seq: iterative RV32M multiply/divide sequencer; MD_FAST_MUL_EN selects a single-cycle multiplier
module md_seq
  import md_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_vld,
  input  logic            i_md,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic [4:0]      i_rd_waddr,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_res,
  output logic [4:0]      o_rd_waddr,
  output logic            o_busy
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  md_state_e state, state_nxt;
  logic [2:0] f3_q;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, acc_nxt, acc_mul, acc_div, prod;
  logic [XLEN-1:0] opb, a1, a2, drem, quo, rem, fin_res, sp_res, fast_res, skip_res;
  logic [XLEN:0] hi_sum;
  logic neg_q, rneg_q, start, is_div, s1, s2, dz, ovf, fast, skip, last, qb;
  assign start  = i_vld & i_md & (state == ST_IDLE) & ~i_flush;
  assign is_div = i_funct3[2];
  assign s1     = i_op1[XLEN-1] & (is_div ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11));
  assign s2     = i_op2[XLEN-1] & (is_div ? ~i_funct3[0] : ~i_funct3[1]);
  assign a1     = s1 ? -i_op1 : i_op1;
  assign a2     = s2 ? -i_op2 : i_op2;
  assign dz     = is_div & (i_op2 == '0);
  assign ovf    = is_div & ~i_funct3[0] & (i_op1 == MIN) & (&i_op2);
  assign sp_res = dz ? (i_funct3[1] ? i_op1 : '1) : (i_funct3[1] ? '0 : MIN);
`ifdef MD_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fprod;
  assign fprod    = $signed({s1, i_op1}) * $signed({s2, i_op2});
  assign fast     = ~is_div;
  assign fast_res = (i_funct3 == MD_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif
  assign skip     = is_div ? (dz | ovf) : fast;
  assign skip_res = is_div ? sp_res : fast_res;
  assign last     = cnt == CW'(XLEN - 1);
  // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}
  assign hi_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
  assign acc_mul = acc[0] ? {hi_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
  md_div_step #(.XLEN(XLEN)) u_step (
    .rem    (acc[2*XLEN-1:XLEN]),
    .dvs    (opb),
    .din    (acc[XLEN-1]),
    .rem_nxt(drem),
    .q      (qb)
  );
  assign acc_div = {drem, acc[XLEN-2:0], qb};
  assign acc_nxt = (state == ST_DIV) ? acc_div : acc_mul;
  assign prod    = neg_q ? -acc_nxt : acc_nxt;
  assign quo     = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
  assign rem     = rneg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
  assign fin_res = (state == ST_DIV) ? (f3_q[1] ? rem : quo)
                 : ((f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  always_ff @(posedge i_clk)
    state <= i_rst ? ST_IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    o_stall   = start | (state == ST_MUL) | (state == ST_DIV);
    o_done    = state == ST_DONE;
    o_busy    = state != ST_IDLE;
    unique case (state)
      ST_IDLE:        if (start) state_nxt = skip ? ST_DONE : (is_div ? ST_DIV : ST_MUL);
      ST_MUL, ST_DIV: state_nxt = i_flush ? ST_IDLE : (last ? ST_DONE : state);
      default:        state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      f3_q       <= '0;
      o_rd_waddr <= '0;
      o_res      <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      opb        <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else if (start) begin
      f3_q       <= i_funct3;
      o_rd_waddr <= i_rd_waddr;
      neg_q      <= s1 ^ s2;
      rneg_q     <= s1;
      opb        <= a2;
      acc        <= {{XLEN{1'b0}}, a1};
      cnt        <= '0;
      if (skip) o_res <= skip_res;
    end else if ((state == ST_MUL) | (state == ST_DIV)) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last) o_res <= fin_res;
    end
  end
endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq: directed table-driven bench for md_seq plus flush, reset and back-to-back sequences
module tb_md_seq;
  logic        i_clk = 1'b0;
  logic        i_rst, i_vld, i_md, i_flush;
  logic [2:0]  i_funct3;
  logic [31:0] i_op1, i_op2;
  logic [4:0]  i_rd_waddr;
  logic        o_stall, o_done, o_busy;
  logic [31:0] o_res;
  logic [4:0]  o_rd_waddr;
  int n_run = 0, n_fail = 0;
`ifdef MD_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  md_seq dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_vld     (i_vld),
    .i_md      (i_md),
    .i_funct3  (i_funct3),
    .i_op1     (i_op1),
    .i_op2     (i_op2),
    .i_rd_waddr(i_rd_waddr),
    .i_flush   (i_flush),
    .o_stall   (o_stall),
    .o_done    (o_done),
    .o_res     (o_res),
    .o_rd_waddr(o_rd_waddr),
    .o_busy    (o_busy)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    #2;
  endtask
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output int bad_stall);
    i_vld = 1'b1; i_md = 1'b1; i_funct3 = f3; i_op1 = a; i_op2 = b; i_rd_waddr = rd;
    #1;
    bad_stall = (o_stall !== 1'b1) ? 1 : 0;
    lat = -1; res = 'x; rdo = 'x;
    for (int k = 1; k <= 50; k++) begin
      step();
      i_vld = 1'b0;
      #1;
      if (o_done === 1'b1) begin
        lat = k; res = o_res; rdo = o_rd_waddr;
        if (o_stall !== 1'b0) bad_stall++;
        break;
      end
      if (o_stall !== 1'b1) bad_stall++;
    end
    step();
  endtask
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t v[16];
  initial begin
    logic [31:0] res;
    logic [4:0]  rdo;
    int lat, bad, nd, n;
    v[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, ML};
    v[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, ML};
    v[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, ML};
    v[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, ML};
    v[4]  = '{3'b000, 32'h12345678, 32'h10,       5'd9,  32'h23456780, ML};
    v[5]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33};
    v[6]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33};
    v[7]  = '{3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       33};
    v[8]  = '{3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        33};
    v[9]  = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD, 33};
    v[10] = '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd15, 32'd1,        33};
    v[11] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        33};
    v[12] = '{3'b100, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 1};
    v[13] = '{3'b110, 32'd5,        32'd0,        5'd18, 32'd5,        1};
    v[14] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1};
    v[15] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'd0,        1};
    i_rst = 1'b1; i_vld = 1'b0; i_md = 1'b0; i_flush = 1'b0;
    i_funct3 = '0; i_op1 = '0; i_op2 = '0; i_rd_waddr = '0;
    step(); step();
    chk("rst_done", 32'(o_done), 0);
    chk("rst_res", o_res, 0);
    chk("rst_rd", 32'(o_rd_waddr), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_stall", 32'(o_stall), 0);
    i_rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      run_op(v[i].f3, v[i].a, v[i].b, v[i].rd, res, rdo, lat, bad);
      chk($sformatf("vec%0d_res", i), res, v[i].res);
      chk($sformatf("vec%0d_lat", i), lat, v[i].lat);
      chk($sformatf("vec%0d_rd", i), 32'(rdo), 32'(v[i].rd));
      chk($sformatf("vec%0d_stall", i), bad, 0);
    end
    i_vld = 1'b1; i_md = 1'b1; i_flush = 1'b1; i_funct3 = 3'b101; i_op1 = 32'd100; i_op2 = 32'd7;
    #1;
    chk("idle_flush_stall", 32'(o_stall), 0);
    step();
    chk("idle_flush_busy", 32'(o_busy), 0);
    i_vld = 1'b0; i_flush = 1'b0;
    step();
    i_vld = 1'b1;
    step();
    i_vld = 1'b0;
    repeat (9) step();
    chk("div_flush_busy_before", 32'(o_busy), 1);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    #1;
    chk("div_flush_busy", 32'(o_busy), 0);
    chk("div_flush_stall", 32'(o_stall), 0);
    nd = 0;
    repeat (40) begin step(); if (o_done === 1'b1) nd++; end
    chk("div_flush_no_done", nd, 0);
    i_vld = 1'b1; i_funct3 = 3'b000; i_op1 = 32'd7; i_op2 = 32'd3;
    step();
    i_vld = 1'b0;
    repeat (4) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    #1;
    chk("mul_rst_busy", 32'(o_busy), 0);
    chk("mul_rst_stall", 32'(o_stall), 0);
    nd = 0;
    repeat (40) begin step(); if (o_done === 1'b1) nd++; end
    chk("mul_rst_no_done", nd, 0);
    i_vld = 1'b1; i_funct3 = 3'b000; i_op1 = 32'd3; i_op2 = 32'd4; i_rd_waddr = 5'd1;
    step();
    i_funct3 = 3'b101; i_op1 = 32'd100; i_op2 = 32'd7; i_rd_waddr = 5'd2;
    n = 0;
    while (o_done !== 1'b1 && n < 60) begin step(); n++; end
    chk("b2b_first_res", o_res, 12);
    chk("b2b_first_rd", 32'(o_rd_waddr), 1);
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 1) chk("b2b_second_start_stall", 32'(o_stall), 1);
      if (k == 2) i_vld = 1'b0;
      if (o_done === 1'b1) begin n = k; break; end
    end
    chk("b2b_gap", n, 34);
    chk("b2b_second_res", o_res, 14);
    chk("b2b_second_rd", 32'(o_rd_waddr), 2);
    step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
